// File: rtl/ddr3_axi_slave_mem.sv
// AXI4 slave backed by an on-chip word array, standing in for a DDR3 memory model.
// Every burst is INCR with a full-bus-width beat stride. The read and write channels
// are independent and run concurrently.
// Optional feature: define DDR3_AXI_SLAVE_MEM_RANGE_CHECK_EN to flag beats that fall
// past the top of the array instead of wrapping them.
module ddr3_axi_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int MEM_ADDR_BITS      = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  // write address
  input  logic [31:0]                     s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  // write data
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  // write response
  output logic [1:0]                      s_axi_bresp,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  // read address
  input  logic [31:0]                     s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic [C_S_AXI_ID_WIDTH:0]       s_axi_arid,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  // read data
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic [C_S_AXI_ID_WIDTH:0]       s_axi_rid,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned DEPTH  = 1 << MEM_ADDR_BITS;
  localparam int unsigned HI_LSB = OFFS + MEM_ADDR_BITS;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [C_M_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t                 w_state;
  logic [MEM_ADDR_BITS-1:0] widx;
  logic [7:0]               wlen;
  logic [7:0]               wcnt;
  logic                     werr;
  logic                     woor;

  r_state_t                 r_state;
  logic [MEM_ADDR_BITS-1:0] ridx;
  logic [7:0]               rlen;
  logic [7:0]               rcnt;

  logic w_fire;
  logic w_last_beat;
  logic w_beat_err;
  logic w_keep;
  logic w_oor_start;
  logic r_oor_start;
  logic r_oor_next;
  logic [1:0] bresp_final;

  // Address bits below the beat stride, size and burst type do not affect this model.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, s_axi_awsize, s_axi_arsize,
                       s_axi_awburst, s_axi_arburst};

  assign w_fire      = s_axi_wvalid & s_axi_wready;
  assign w_last_beat = (wcnt == wlen);
  assign w_beat_err  = s_axi_wlast ^ w_last_beat;
  assign w_keep      = ~woor;

`ifdef DDR3_AXI_SLAVE_MEM_RANGE_CHECK_EN
  // Out of range once the untruncated index passes the top; it never comes back in range.
  assign w_oor_start = |s_axi_awaddr[31:HI_LSB];
  assign r_oor_start = |s_axi_araddr[31:HI_LSB];
  assign r_oor_next  = s_axi_rresp[1] | (&ridx);
  assign bresp_final = (werr | w_beat_err | woor) ? 2'b10 : 2'b00;
`else
  assign w_oor_start = 1'b0;
  assign r_oor_start = 1'b0;
  assign r_oor_next  = 1'b0;
  assign bresp_final = (werr | w_beat_err) ? 2'b10 : 2'b00;
`endif

  // Write channel FSM: address latch, data beats, single response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      widx          <= '0;
      wlen          <= '0;
      wcnt          <= '0;
      werr          <= 1'b0;
      woor          <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      s_axi_bid     <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            widx          <= s_axi_awaddr[OFFS +: MEM_ADDR_BITS];
            wlen          <= s_axi_awlen;
            wcnt          <= '0;
            werr          <= 1'b0;
            woor          <= w_oor_start;
            s_axi_bid     <= s_axi_awid;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            widx <= widx + MEM_ADDR_BITS'(1);
            wcnt <= wcnt + 8'd1;
            werr <= werr | w_beat_err;
            woor <= woor | w_oor_start_next(widx);
            // Beat count alone closes the burst; a misplaced wlast only flags the response.
            if (w_last_beat) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= bresp_final;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Next-beat out-of-range flag for the write side; constant 0 without range checking.
  function automatic logic w_oor_start_next(input logic [MEM_ADDR_BITS-1:0] idx);
`ifdef DDR3_AXI_SLAVE_MEM_RANGE_CHECK_EN
    return &idx;
`else
    return 1'b0 & (^idx);
`endif
  endfunction

  // Byte-enabled array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_fire && w_keep) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read channel FSM: address latch, then one beat per rready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      ridx          <= '0;
      rlen          <= '0;
      rcnt          <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rid     <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            ridx          <= s_axi_araddr[OFFS +: MEM_ADDR_BITS];
            rlen          <= s_axi_arlen;
            rcnt          <= '0;
            s_axi_rid     <= s_axi_arid;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rresp   <= r_oor_start ? 2'b10 : 2'b00;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_rresp   <= 2'b00;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              ridx        <= ridx + MEM_ADDR_BITS'(1);
              rcnt        <= rcnt + 8'd1;
              s_axi_rlast <= ((rcnt + 8'd1) == rlen);
              s_axi_rresp <= r_oor_next ? 2'b10 : 2'b00;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Combinational array read: a same-cycle write is seen only after the clock edge.
  assign s_axi_rdata = s_axi_rresp[1] ? '0 : mem[ridx];

endmodule

// File: tb/tb_ddr3_axi_slave_mem.sv
// Randomized self-checking bench for ddr3_axi_slave_mem against a flat word-array model.
module tb_ddr3_axi_slave_mem;

  localparam int DW    = 512;
  localparam int IDW   = 4;
  localparam int MAB   = 10;
  localparam int DEPTH = 1 << MAB;
`ifdef DDR3_AXI_SLAVE_MEM_RANGE_CHECK_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    s_axi_awaddr;
  logic [7:0]     s_axi_awlen;
  logic [2:0]     s_axi_awsize;
  logic [1:0]     s_axi_awburst;
  logic [IDW-1:0] s_axi_awid;
  logic           s_axi_awvalid;
  logic           s_axi_awready;
  logic [DW-1:0]  s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic           s_axi_wlast;
  logic           s_axi_wvalid;
  logic           s_axi_wready;
  logic [1:0]     s_axi_bresp;
  logic [IDW-1:0] s_axi_bid;
  logic           s_axi_bvalid;
  logic           s_axi_bready;
  logic [31:0]    s_axi_araddr;
  logic [7:0]     s_axi_arlen;
  logic [2:0]     s_axi_arsize;
  logic [1:0]     s_axi_arburst;
  logic [IDW:0]   s_axi_arid;
  logic           s_axi_arvalid;
  logic           s_axi_arready;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic [IDW:0]   s_axi_rid;
  logic           s_axi_rvalid;
  logic           s_axi_rready;

  ddr3_axi_slave_mem #(
    .C_S_AXI_ID_WIDTH  (IDW),
    .C_M_AXI_DATA_WIDTH(DW),
    .MEM_ADDR_BITS     (MAB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awlen  (s_axi_awlen),
    .s_axi_awsize (s_axi_awsize),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_awid   (s_axi_awid),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wlast  (s_axi_wlast),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bid    (s_axi_bid),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arlen  (s_axi_arlen),
    .s_axi_arsize (s_axi_arsize),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_arid   (s_axi_arid),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rlast  (s_axi_rlast),
    .s_axi_rid    (s_axi_rid),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] rd_q [$];

  // Count one comparison and report it if it differs.
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input int full);
    if (OOR_EN && full >= DEPTH) return '0;
    return model[full % DEPTH];
  endfunction

  function automatic logic [1:0] exp_resp(input int full);
    return (OOR_EN && full >= DEPTH) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // mode 0: random data/strobes, 1: data = beat number, 2: fixed data/strobes, 3: random data, full strobes
  task automatic wr_burst(input logic [31:0] addr, input int len, input logic [IDW-1:0] id,
                          input int wlast_beat, input int mode,
                          input logic [DW-1:0] fdata, input logic [DW/8-1:0] fstrb);
    logic [DW-1:0]   d;
    logic [DW/8-1:0] s;
    logic [1:0]      eresp;
    int n, base, full;
    base  = int'(addr >> 6);
    eresp = (wlast_beat != len) ? 2'b10 : 2'b00;
    s_axi_awaddr  = addr;
    s_axi_awlen   = 8'(len);
    s_axi_awid    = id;
    s_axi_awsize  = 3'($urandom);
    s_axi_awburst = 2'($urandom);
    s_axi_awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_awready && n < 200);
    if (!s_axi_awready) begin
      check("aw_timeout", 0, 1);
      s_axi_awvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      case (mode)
        0:       begin d = rand_word(); s = {$urandom, $urandom}; end
        1:       begin d = DW'(i); s = '1; end
        2:       begin d = fdata; s = fstrb; end
        default: begin d = rand_word(); s = '1; end
      endcase
      if (mode == 0 && ($urandom % 4) == 0) begin
        s_axi_wvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axi_wdata  = d;
      s_axi_wstrb  = s;
      s_axi_wlast  = (i == wlast_beat);
      s_axi_wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_axi_wready && n < 50);
      if (!s_axi_wready) begin
        check("w_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      full = base + i;
      if (OOR_EN && full >= DEPTH) eresp = 2'b10;
      else begin
        for (int b = 0; b < DW/8; b++)
          if (s[b]) model[full % DEPTH][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    @(negedge clk);
    check("bvalid_lat", s_axi_bvalid, 1);
    check("w_closed", s_axi_wready, 0);
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    check("bid", s_axi_bid, id);
    check("bresp", s_axi_bresp, eresp);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  // rmode 0: rready always 1, 1: toggles 1-0-1, 2: random
  task automatic rd_burst(input logic [31:0] addr, input int len, input logic [IDW:0] id, input int rmode);
    int n, beats, base;
    bit done, prev_stall;
    logic [DW-1:0] prev;
    rd_q.delete();
    base = int'(addr >> 6);
    s_axi_araddr  = addr;
    s_axi_arlen   = 8'(len);
    s_axi_arid    = id;
    s_axi_arsize  = 3'($urandom);
    s_axi_arburst = 2'($urandom);
    s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 200);
    if (!s_axi_arready) begin
      check("ar_timeout", 0, 1);
      s_axi_arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    beats = 0; done = 1'b0; prev_stall = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      case (rmode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = (cyc % 2 == 0);
        default: s_axi_rready = 1'($urandom);
      endcase
      @(negedge clk);
      if (cyc == 0) check("rvalid_lat", s_axi_rvalid, 1);
      if (s_axi_rvalid) begin
        check("rdata", s_axi_rdata, exp_word(base + beats));
        check("rresp", s_axi_rresp, exp_resp(base + beats));
        check("rid", s_axi_rid, id);
        check("rlast", s_axi_rlast, (beats == len));
        if (prev_stall) check("r_hold", s_axi_rdata, prev);
        prev = s_axi_rdata;
        prev_stall = !s_axi_rready;
        if (s_axi_rready) begin
          rd_q.push_back(s_axi_rdata);
          beats++;
          done = (s_axi_rlast === 1'b1);
        end
      end
      @(posedge clk); #1;
    end
    s_axi_rready = 1'b0;
    check("r_beats", beats, len + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old5, newd;
    int n, idx, len;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awid = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arid = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", s_axi_awready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_ids", {s_axi_bid, s_axi_rid}, 0);
    check("rst_resp", {s_axi_bresp, s_axi_rresp}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_awready", s_axi_awready, 1);
    check("rel_arready", s_axi_arready, 1);
    @(posedge clk); #1;

    // Give every word a known value
    for (int k = 0; k < 4; k++) wr_burst(32'(k * 256 * 64), 255, 4'h0, 255, 3, '0, '0);

    // 16-beat burst of beat numbers, read back
    wr_burst(32'h0, 15, 4'h3, 15, 1, '0, '0);
    rd_burst(32'h0, 15, 5'h11, 0);
    for (int i = 0; i < 16; i++) check("seq_data", (i < rd_q.size()) ? rd_q[i] : 'x, DW'(i));

    // Partial strobe over a zeroed word
    wr_burst(32'h40, 0, 4'h1, 0, 2, '0, '1);
    wr_burst(32'h40, 0, 4'h2, 0, 2, '1, 64'h0000_0000_0000_000F);
    rd_burst(32'h40, 0, 5'h02, 0);
    check("strb_word", (rd_q.size() > 0) ? rd_q[0] : 'x, DW'(32'hFFFF_FFFF));

    // rready stalls on a 4-beat read
    rd_burst(32'h100, 3, 5'h05, 1);

    // Early wlast: all beats still taken, SLVERR
    wr_burst(32'h200, 3, 4'h9, 1, 0, '0, '0);
    rd_burst(32'h200, 3, 5'h09, 2);

    // Burst across the top of the array
    wr_burst(32'((DEPTH - 2) * 64), 3, 4'hA, 3, 0, '0, '0);
    rd_burst(32'((DEPTH - 2) * 64), 3, 5'h0A, 2);

    // Same-cycle write and read of word 5
    old5 = model[5];
    newd = rand_word();
    s_axi_awaddr = 32'h140; s_axi_awlen = 8'd0; s_axi_awid = 4'h7; s_axi_awvalid = 1'b1;
    s_axi_araddr = 32'h140; s_axi_arlen = 8'd0; s_axi_arid = 5'h0C; s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(s_axi_awready && s_axi_arready) && n < 50);
    check("cc_ready", {s_axi_awready, s_axi_arready}, 2'b11);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_wdata = newd; s_axi_wstrb = '1; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_rready = 1'b1;
    @(negedge clk);
    check("cc_wready", s_axi_wready, 1);
    check("cc_rvalid", s_axi_rvalid, 1);
    check("cc_old", s_axi_rdata, old5);
    check("cc_rlast", s_axi_rlast, 1);
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_rready = 1'b0;
    model[5] = newd;
    @(negedge clk);
    check("cc_bvalid", s_axi_bvalid, 1);
    check("cc_bresp", s_axi_bresp, 2'b00);
    check("cc_bid", s_axi_bid, 4'h7);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    rd_burst(32'h140, 0, 5'h0D, 0);
    check("cc_new", (rd_q.size() > 0) ? rd_q[0] : 'x, newd);

    // Random traffic
    for (int t = 0; t < 16; t++) begin
      idx = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(0, 15);
      wr_burst(32'(idx * 64), len, 4'($urandom), len, 0, '0, '0);
      rd_burst(32'(idx * 64), len, 5'($urandom), 2);
      idx = $urandom_range(0, DEPTH - 1);
      rd_burst(32'(idx * 64), $urandom_range(0, 7), 5'($urandom), 2);
    end

    // Reset during beat 3 of an 8-beat read
    s_axi_araddr = 32'h0; s_axi_arlen = 8'd7; s_axi_arid = 5'h1F; s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 50);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mid_rvalid", s_axi_rvalid, 1);
    check("mid_rdata", s_axi_rdata, model[2]);
    #1 rst = 1'b1;
    #1;
    check("arst_rvalid", s_axi_rvalid, 0);
    check("arst_arready", s_axi_arready, 0);
    s_axi_rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_arready", s_axi_arready, 1);
    check("post_awready", s_axi_awready, 1);
    check("post_bvalid", s_axi_bvalid, 0);
    @(posedge clk); #1;
    rd_burst(32'h80, 1, 5'h03, 0);

    // Index at the array top: flagged with range checking, wrapped otherwise
    rd_burst(32'(DEPTH * 64), 1, 5'h04, 0);
    wr_burst(32'((DEPTH - 1) * 64), 1, 4'h5, 1, 3, '0, '0);
    rd_burst(32'h0, 0, 5'h06, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
